// File: rtl/mac_pkg.sv
// Shared types and widths for the 4-bit MAC matrix-multiply datapath.
package mac_pkg;
  localparam int W_IN  = 4;
  localparam int W_ACC = 10;
  localparam int MAX_N = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    WRT,
    DONE
  } seq_state_t;
endpackage

// File: rtl/mac_idx_gen.sv
// Row/column/inner-product counters and the row-major addresses derived from them.
module mac_idx_gen #(
  parameter  int N  = 2,
  localparam int AW = $clog2(N*N),
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step_k,
  input  logic          step_ij,
  output logic          last_k,
  output logic          last_ij,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr
);
  localparam logic [CW-1:0] LAST = CW'(N-1);
  localparam logic [AW-1:0] NA   = AW'(N);

  logic [CW-1:0] r_i, r_j, r_k;
  logic [AW-1:0] w_i, w_j, w_k;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (step_ij) begin
      r_k <= '0;
      if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end else if (step_k) begin
      r_k <= r_k + 1'b1;
    end
  end

  assign w_i     = AW'(r_i);
  assign w_j     = AW'(r_j);
  assign w_k     = AW'(r_k);
  assign last_k  = (r_k == LAST);
  assign last_ij = (r_i == LAST) && (r_j == LAST);
  assign a_addr  = w_i * NA + w_k;
  assign b_addr  = w_k * NA + w_j;
  assign c_addr  = w_i * NA + w_j;
endmodule

// File: rtl/mac_matmul_seq.sv
// Sequencer driving one shared MAC to compute C = A x B, one MAC operation per cycle.
module mac_matmul_seq
  import mac_pkg::*;
#(
  parameter  int N  = 2,
  localparam int AW = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    a_addr,
  output logic [AW-1:0]    b_addr,
  input  logic [W_IN-1:0]  a_data,
  input  logic [W_IN-1:0]  b_data,
  output logic [W_IN-1:0]  mac_w,
  output logic [W_IN-1:0]  mac_x,
  output logic             mac_load,
  output logic             mac_clear,
  input  logic [W_ACC-1:0] mac_o,
  output logic             c_wr_en,
  output logic [AW-1:0]    c_addr,
  output logic [W_ACC-1:0] c_data
);
  seq_state_t    r_state, w_next;
  logic          w_clr_idx, w_step_k, w_step_ij;
  logic          w_last_k, w_last_ij;
  logic [AW-1:0] w_a_addr, w_b_addr, w_c_addr;

  mac_idx_gen #(.N(N)) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr_idx),
    .step_k  (w_step_k),
    .step_ij (w_step_ij),
    .last_k  (w_last_k),
    .last_ij (w_last_ij),
    .a_addr  (w_a_addr),
    .b_addr  (w_b_addr),
    .c_addr  (w_c_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs depend only on the registered state; abort only redirects the next state.
  always_comb begin
    w_next    = r_state;
    w_clr_idx = 1'b0;
    w_step_k  = 1'b0;
    w_step_ij = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    a_addr    = '0;
    b_addr    = '0;
    mac_w     = '0;
    mac_x     = '0;
    mac_load  = 1'b0;
    mac_clear = 1'b0;
    c_wr_en   = 1'b0;
    c_addr    = '0;
    c_data    = '0;
    case (r_state)
      IDLE: begin
        w_clr_idx = 1'b1;
        if (start && !abort) w_next = CLR;
      end
      CLR: begin
        mac_clear = 1'b1;
        w_next    = ACC;
      end
      ACC: begin
        a_addr   = w_a_addr;
        b_addr   = w_b_addr;
        mac_w    = a_data;
        mac_x    = b_data;
        mac_load = 1'b1;
        w_step_k = !w_last_k;
        w_next   = w_last_k ? WRT : ACC;
      end
      WRT: begin
        c_wr_en   = 1'b1;
        c_addr    = w_c_addr;
        c_data    = mac_o;
        w_step_ij = 1'b1;
        w_next    = w_last_ij ? DONE : CLR;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE) begin
      busy = 1'b1;
      if (abort) w_next = IDLE;
    end
  end
endmodule

// File: tb/tb_mac_matmul_seq.sv
// Directed bench: N=2 and N=4 sequencers, each paired with a behavioural MAC and operand stores.
module tb_mac_matmul_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // N = 2 instance
  logic       st2, ab2, busy2, done2, ml2, mc2, we2;
  logic [1:0] aa2, ba2, ca2;
  logic [3:0] ad2, bd2, mw2, mx2;
  logic [9:0] mo2, cd2;
  logic [3:0] a2 [4];
  logic [3:0] b2 [4];
  logic [9:0] acc2 = '0;

  // N = 4 instance
  logic       st4, ab4, busy4, done4, ml4, mc4, we4;
  logic [3:0] aa4, ba4, ca4;
  logic [3:0] ad4, bd4, mw4, mx4;
  logic [9:0] mo4, cd4;
  logic [9:0] acc4 = '0;

  assign ad2 = a2[aa2];
  assign bd2 = b2[ba2];
  assign mo2 = acc2;
  assign ad4 = 4'd15;
  assign bd4 = 4'd15;
  assign mo4 = acc4;

  always @(posedge clk) begin
    if (mc2)      acc2 <= '0;
    else if (ml2) acc2 <= acc2 + mw2 * mx2;
    if (mc4)      acc4 <= '0;
    else if (ml4) acc4 <= acc4 + mw4 * mx4;
  end

  mac_matmul_seq #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .abort(ab2), .busy(busy2), .done(done2),
    .a_addr(aa2), .b_addr(ba2), .a_data(ad2), .b_data(bd2), .mac_w(mw2), .mac_x(mx2),
    .mac_load(ml2), .mac_clear(mc2), .mac_o(mo2), .c_wr_en(we2), .c_addr(ca2), .c_data(cd2)
  );

  mac_matmul_seq #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .abort(ab4), .busy(busy4), .done(done4),
    .a_addr(aa4), .b_addr(ba4), .a_data(ad4), .b_data(bd4), .mac_w(mw4), .mac_x(mx4),
    .mac_load(ml4), .mac_clear(mc4), .mac_o(mo4), .c_wr_en(we4), .c_addr(ca4), .c_data(cd4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_mats2(input logic [15:0] a, input logic [15:0] b);
    for (int n = 0; n < 4; n++) begin
      a2[n] = a[15-4*n -: 4];
      b2[n] = b[15-4*n -: 4];
    end
  endtask

  // Full N=2 multiply started at the next negedge (cycle 0); e0..e3 are the hand-computed C.
  task automatic run2(input string nm, input logic [9:0] e0, input logic [9:0] e1,
                      input logic [9:0] e2, input logic [9:0] e3, input bit noise);
    logic [9:0] ex [4];
    int e, i, j, k;
    ex = '{e0, e1, e2, e3};
    @(negedge clk);
    st2 = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      st2 = noise && (c >= 2) && (c <= 10);
      e = (c - 1) / 4;
      i = e / 2;
      j = e % 2;
      k = (c % 4) - 2;
      chk($sformatf("%s busy c%0d", nm, c), busy2, c <= 17);
      chk($sformatf("%s done c%0d", nm, c), done2, c == 17);
      chk($sformatf("%s wr_en c%0d", nm, c), we2, (c <= 16) && (c % 4 == 0));
      chk($sformatf("%s clear c%0d", nm, c), mc2, (c <= 16) && (c % 4 == 1));
      chk($sformatf("%s load c%0d", nm, c), ml2, (c <= 16) && (k == 0 || k == 1));
      if (c <= 16 && (k == 0 || k == 1)) begin
        chk($sformatf("%s a_addr c%0d", nm, c), aa2, i * 2 + k);
        chk($sformatf("%s b_addr c%0d", nm, c), ba2, k * 2 + j);
        chk($sformatf("%s mac_w c%0d", nm, c), mw2, a2[i * 2 + k]);
        chk($sformatf("%s mac_x c%0d", nm, c), mx2, b2[k * 2 + j]);
      end
      if (c <= 16 && c % 4 == 0) begin
        chk($sformatf("%s c_addr c%0d", nm, c), ca2, c / 4 - 1);
        chk($sformatf("%s c_data c%0d", nm, c), cd2, ex[c / 4 - 1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st2 = 1'b0; ab2 = 1'b0; st4 = 1'b0; ab4 = 1'b0;
    set_mats2(16'h1234, 16'h5678);
    repeat (3) @(negedge clk);
    chk("rst busy", busy2, 0);
    chk("rst done", done2, 0);
    chk("rst wr_en", we2, 0);
    chk("rst load", ml2, 0);
    chk("rst clear", mc2, 0);
    chk("rst addrs", {aa2, ba2, ca2}, 0);
    chk("rst data", {mw2, mx2, cd2}, 0);
    chk("rst busy4", busy4, 0);
    rst_n = 1'b1;

    run2("mul", 10'd19, 10'd22, 10'd43, 10'd50, 1'b0);

    set_mats2(16'h1001, 16'h930F);
    run2("ident", 10'd9, 10'd3, 10'd0, 10'd15, 1'b0);

    set_mats2(16'h1234, 16'h5678);
    run2("restart", 10'd19, 10'd22, 10'd43, 10'd50, 1'b1);

    @(negedge clk);
    st2 = 1'b1;
    ab2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    ab2 = 1'b0;
    chk("start+abort busy", busy2, 0);
    @(negedge clk);
    chk("start+abort busy2", busy2, 0);

    @(negedge clk);
    st2 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      st2 = 1'b0;
      ab2 = (c == 6);
      chk($sformatf("abort busy c%0d", c), busy2, c <= 6);
      chk($sformatf("abort wr_en c%0d", c), we2, c == 4);
      chk($sformatf("abort done c%0d", c), done2, 0);
    end
    run2("after_abort", 10'd19, 10'd22, 10'd43, 10'd50, 1'b0);

    @(negedge clk);
    st2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      st2 = 1'b0;
      rst_n = (c != 9);
      if (c < 9) chk($sformatf("prerst busy c%0d", c), busy2, 1);
      if (c >= 10) begin
        chk($sformatf("midrst busy c%0d", c), busy2, 0);
        chk($sformatf("midrst done c%0d", c), done2, 0);
        chk($sformatf("midrst ctrl c%0d", c), {we2, ml2, mc2}, 0);
        chk($sformatf("midrst bus c%0d", c), {aa2, ba2, ca2, mw2, mx2, cd2}, 0);
      end
    end
    run2("after_rst", 10'd19, 10'd22, 10'd43, 10'd50, 1'b0);

    @(negedge clk);
    st4 = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      st4 = 1'b0;
      chk($sformatf("n4 busy c%0d", c), busy4, c <= 97);
      chk($sformatf("n4 done c%0d", c), done4, c == 97);
      chk($sformatf("n4 wr_en c%0d", c), we4, (c <= 96) && (c % 6 == 0));
      if (c <= 96 && c % 6 == 0) begin
        chk($sformatf("n4 c_addr c%0d", c), ca4, c / 6 - 1);
        chk($sformatf("n4 c_data c%0d", c), cd4, 900);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
